// File: rtl/ocp_arb_pkg.sv
// Shared command/response codes and FSM state encodings for the two-master OCP arbiter.
package ocp_arb_pkg;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;
  localparam logic [1:0] RESP_TMO  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMD  = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_ERR  = 2'd3;

  function automatic logic cmd_legal(input logic [2:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/ocp_rr_pick.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the master not granted last.
module ocp_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;
  assign gnt_idx   = (&req) ? ~last : req[1];

endmodule

// File: rtl/ocp_bus_arbiter.sv
// Arbitrates two OCP masters onto one slave, one transaction outstanding at a time.
// state | meaning: IDLE wait for request | CMD forward owner cmd | RESP wait slave resp/timeout | ERR illegal cmd reply
module ocp_bus_arbiter
  import ocp_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] m0_MCmd,
  input  logic [7:0] m0_MAddr,
  input  logic [7:0] m0_MData,
  output logic       m0_SCmdAccept,
  output logic [7:0] m0_SData,
  output logic [1:0] m0_SResp,
  input  logic [2:0] m1_MCmd,
  input  logic [7:0] m1_MAddr,
  input  logic [7:0] m1_MData,
  output logic       m1_SCmdAccept,
  output logic [7:0] m1_SData,
  output logic [1:0] m1_SResp,
  output logic [2:0] s_MCmd,
  output logic [7:0] s_MAddr,
  output logic [7:0] s_MData,
  input  logic       s_SCmdAccept,
  input  logic [7:0] s_SData,
  input  logic [1:0] s_SResp,
  output logic       arb_busy,
  output logic       arb_owner
);

  state_t     state;
  logic       owner;
  logic       last;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [1:0] req;
  logic       gnt_valid;
  logic       gnt_idx;
  logic [2:0] win_cmd;
  logic [2:0] own_cmd;
  logic [7:0] own_addr;
  logic [7:0] own_data;
  logic       rsp_seen;
  logic       tmo_hit;
  logic       o_acc;
  logic [1:0] o_resp;
  logic [7:0] o_data;

  assign req = {m1_MCmd != CMD_IDLE, m0_MCmd != CMD_IDLE};

  ocp_rr_pick u_pick (
    .req       (req),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign win_cmd  = gnt_idx ? m1_MCmd  : m0_MCmd;
  assign own_cmd  = owner   ? m1_MCmd  : m0_MCmd;
  assign own_addr = owner   ? m1_MAddr : m0_MAddr;
  assign own_data = owner   ? m1_MData : m0_MData;

  // Saturating increment; the timeout fires on the cycle the count reaches TIMEOUT.
  assign cnt_inc  = (cnt == TIMEOUT) ? cnt : cnt + 8'd1;
  assign rsp_seen = (s_SResp != RESP_NULL);
  assign tmo_hit  = !rsp_seen && (cnt_inc == TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner <= gnt_idx;
            last  <= gnt_idx;
            state <= cmd_legal(win_cmd) ? ST_CMD : ST_ERR;
          end
        end
        ST_CMD: begin
          if (s_SCmdAccept) begin
            state <= ST_RESP;
            cnt   <= 8'd0;
          end
        end
        ST_RESP: begin
          if (rsp_seen || tmo_hit) state <= ST_IDLE;
          else                     cnt   <= cnt_inc;
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates every output so an in-flight transaction is dropped silently.
  always_comb begin
    s_MCmd  = CMD_IDLE;
    s_MAddr = 8'd0;
    s_MData = 8'd0;
    o_acc   = 1'b0;
    o_resp  = RESP_NULL;
    o_data  = 8'd0;
    if (!reset) begin
      case (state)
        ST_CMD: begin
          s_MCmd  = own_cmd;
          s_MAddr = own_addr;
          s_MData = own_data;
          o_acc   = s_SCmdAccept;
        end
        ST_RESP: begin
          if (rsp_seen) begin
            o_resp = s_SResp;
            o_data = s_SData;
          end else if (tmo_hit) begin
            o_resp = RESP_TMO;
          end
        end
        ST_ERR: begin
          o_acc  = 1'b1;
          o_resp = RESP_ERR;
        end
        default: ;
      endcase
    end
  end

  assign m0_SCmdAccept = o_acc & ~owner;
  assign m0_SResp      = owner ? RESP_NULL : o_resp;
  assign m0_SData      = owner ? 8'd0 : o_data;
  assign m1_SCmdAccept = o_acc & owner;
  assign m1_SResp      = owner ? o_resp : RESP_NULL;
  assign m1_SData      = owner ? o_data : 8'd0;

  assign arb_busy  = !reset && (state != ST_IDLE);
  assign arb_owner = !reset && owner;

endmodule

// File: tb/tb_ocp_bus_arbiter.sv
// Scoreboard bench: rounds of master requests predicted by a transaction-level model, checked by a monitor.
module tb_ocp_bus_arbiter;

  localparam int TMO = 4;

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
    int         acc;
    int         j;
    logic [1:0] rc;
    logic [7:0] sd;
  } txn_t;

  typedef struct {
    int         idx;
    logic [1:0] resp;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] m0_MCmd = '0, m1_MCmd = '0;
  logic [7:0] m0_MAddr = '0, m0_MData = '0, m1_MAddr = '0, m1_MData = '0;
  logic       m0_SCmdAccept, m1_SCmdAccept;
  logic [7:0] m0_SData, m1_SData;
  logic [1:0] m0_SResp, m1_SResp;
  logic [2:0] s_MCmd;
  logic [7:0] s_MAddr, s_MData;
  logic       s_SCmdAccept = 1'b0;
  logic [7:0] s_SData = '0;
  logic [1:0] s_SResp = '0;
  logic       arb_busy, arb_owner;

  int   tests = 0;
  int   fails = 0;
  int   model_last = 1;
  bit   slave_auto = 1'b1;
  bit   slv_busy = 1'b0;
  exp_t exp_q[$];
  txn_t slv_q[$];

  always #5 clk = ~clk;

  ocp_bus_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .m0_MCmd(m0_MCmd), .m0_MAddr(m0_MAddr), .m0_MData(m0_MData),
    .m0_SCmdAccept(m0_SCmdAccept), .m0_SData(m0_SData), .m0_SResp(m0_SResp),
    .m1_MCmd(m1_MCmd), .m1_MAddr(m1_MAddr), .m1_MData(m1_MData),
    .m1_SCmdAccept(m1_SCmdAccept), .m1_SData(m1_SData), .m1_SResp(m1_SResp),
    .s_MCmd(s_MCmd), .s_MAddr(s_MAddr), .s_MData(s_MData),
    .s_SCmdAccept(s_SCmdAccept), .s_SData(s_SData), .s_SResp(s_SResp),
    .arb_busy(arb_busy), .arb_owner(arb_owner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_m0"}, 32'({m0_SCmdAccept, m0_SResp, m0_SData}), 32'd0);
    check({name, "_m1"}, 32'({m1_SCmdAccept, m1_SResp, m1_SData}), 32'd0);
    check({name, "_slv"}, 32'({s_MCmd, s_MAddr, s_MData}), 32'd0);
    check({name, "_busy_owner"}, 32'({arb_busy, arb_owner}), 32'd0);
  endtask

  task automatic set_master(input int idx, input logic [2:0] c, input logic [7:0] a, input logic [7:0] d);
    if (idx == 0) begin m0_MCmd = c; m0_MAddr = a; m0_MData = d; end
    else          begin m1_MCmd = c; m1_MAddr = a; m1_MData = d; end
  endtask

  task automatic drive_master(input int idx, input txn_t t);
    logic got;
    got = 1'b0;
    set_master(idx, t.cmd, t.addr, t.data);
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = (idx == 0) ? m0_SCmdAccept : m1_SCmdAccept;
    end
    if (!got) check("accept_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    set_master(idx, 3'b000, 8'h00, 8'h00);
  endtask

  // Reference: round robin decided from who requests and who went last; one response per request.
  task automatic run_round(input bit en0, input txn_t t0, input bit en1, input txn_t t1);
    int   order[$];
    txn_t tt;
    exp_t e;
    int   c;
    if (en0 && en1) begin
      order.push_back(1 - model_last);
      order.push_back(model_last);
    end else if (en0) begin
      order.push_back(0);
      model_last = 0;
    end else begin
      order.push_back(1);
      model_last = 1;
    end
    foreach (order[k]) begin
      tt = (order[k] == 1) ? t1 : t0;
      e.idx = order[k];
      if (tt.cmd != 3'b001 && tt.cmd != 3'b010) begin
        e.resp = 2'b10; e.data = 8'h00;
      end else begin
        slv_q.push_back(tt);
        if (tt.j > TMO) begin e.resp = 2'b11; e.data = 8'h00; end
        else            begin e.resp = tt.rc; e.data = tt.sd;  end
      end
      exp_q.push_back(e);
    end
    fork
      begin if (en0) drive_master(0, t0); end
      begin if (en1) drive_master(1, t1); end
    join
    c = 0;
    while ((exp_q.size() != 0 || slv_q.size() != 0 || slv_busy || arb_busy) && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("round_complete", 32'(c < 400), 32'd1);
    if (c >= 400) begin exp_q.delete(); slv_q.delete(); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic txn_t mk(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d,
                              input int acc, input int j, input logic [1:0] rc, input logic [7:0] sd);
    txn_t t;
    t.cmd = c; t.addr = a; t.data = d; t.acc = acc; t.j = j; t.rc = rc; t.sd = sd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   p;
    p = $urandom_range(0, 99);
    t.cmd  = (p < 8) ? 3'($urandom_range(3, 7)) : ((p < 54) ? 3'b010 : 3'b001);
    t.addr = 8'($urandom);
    t.data = 8'($urandom);
    t.acc  = $urandom_range(0, 3);
    t.j    = $urandom_range(1, TMO + 1);
    p = $urandom_range(0, 9);
    t.rc   = (p < 7) ? 2'b01 : ((p < 9) ? 2'b10 : 2'b11);
    t.sd   = 8'($urandom);
    return t;
  endfunction

  // Slave model: accepts after acc cycles, answers on RESP cycle j (late when j > TMO).
  initial begin
    bit   aligned;
    txn_t it;
    aligned = 1'b0;
    forever begin
      if (!aligned) begin @(posedge clk); #1; end
      aligned = 1'b0;
      if (slave_auto && !reset && s_MCmd != 3'b000) begin
        slv_busy = 1'b1;
        if (slv_q.size() == 0) begin
          check("slave_unexpected_cmd", 32'(s_MCmd), 32'd0);
        end else begin
          it = slv_q.pop_front();
          for (int k = 0; k <= it.acc; k++) begin
            check("slave_cmd", 32'(s_MCmd), 32'(it.cmd));
            check("slave_addr", 32'(s_MAddr), 32'(it.addr));
            check("slave_data", 32'(s_MData), 32'(it.data));
            s_SCmdAccept = (k == it.acc);
            @(posedge clk); #1;
          end
          s_SCmdAccept = 1'b0;
          for (int k = 1; k <= it.j; k++) begin
            if (k == it.j) begin s_SResp = it.rc; s_SData = it.sd; end
            @(posedge clk); #1;
          end
          s_SResp = 2'b00;
          s_SData = 8'h00;
          aligned = 1'b1;
        end
        slv_busy = 1'b0;
      end
    end
  end

  // Monitor: every response seen by a master must match the head of the scoreboard.
  initial begin
    exp_t       e;
    logic [1:0] r;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!arb_busy) check("slave_bus_idle", 32'({s_MCmd, s_MAddr, s_MData}), 32'd0);
        check("accept_both", 32'(m0_SCmdAccept & m1_SCmdAccept), 32'd0);
        for (int i = 0; i < 2; i++) begin
          r = (i == 0) ? m0_SResp : m1_SResp;
          d = (i == 0) ? m0_SData : m1_SData;
          if (r != 2'b00) begin
            if (exp_q.size() == 0) begin
              check("unexpected_resp", 32'({r, d}), 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("resp_master", 32'(i), 32'(e.idx));
              check("resp_code", 32'(r), 32'(e.resp));
              check("resp_data", 32'(d), 32'(e.data));
              check("resp_owner", 32'(arb_owner), 32'(e.idx));
            end
          end else begin
            check("data_without_resp", 32'(d), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t ta, tb;
    int   sel;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Tie after reset: m0 first, then m1; repeated tie keeps alternating.
    run_round(1'b1, mk(3'b010, 8'h21, 8'h00, 0, 1, 2'b01, 8'h11),
              1'b1, mk(3'b001, 8'h22, 8'h99, 1, 2, 2'b01, 8'h00));
    run_round(1'b1, mk(3'b001, 8'h31, 8'h77, 0, 3, 2'b01, 8'h00),
              1'b1, mk(3'b010, 8'h32, 8'h00, 2, 1, 2'b10, 8'hE1));
    // m0 read of 0x10, slave answers 5A.
    run_round(1'b1, mk(3'b010, 8'h10, 8'h00, 0, 2, 2'b01, 8'h5A), 1'b0, mk(3'b000, 0, 0, 0, 1, 0, 0));
    // m1 write with slave holding off accept for 5 cycles.
    run_round(1'b0, mk(3'b000, 0, 0, 0, 1, 0, 0), 1'b1, mk(3'b001, 8'h33, 8'hC4, 5, 1, 2'b01, 8'h00));
    // Slave too slow: timeout on the 4th RESP cycle, late DVA dropped.
    run_round(1'b1, mk(3'b010, 8'h40, 8'h00, 0, TMO + 1, 2'b01, 8'hBE), 1'b0, mk(3'b000, 0, 0, 0, 1, 0, 0));
    // Response exactly on the last allowed RESP cycle wins over the timeout.
    run_round(1'b0, mk(3'b000, 0, 0, 0, 1, 0, 0), 1'b1, mk(3'b010, 8'h41, 8'h00, 1, TMO, 2'b01, 8'h3C));
    // Illegal command.
    run_round(1'b1, mk(3'b011, 8'h50, 8'h12, 0, 1, 2'b01, 8'h00), 1'b0, mk(3'b000, 0, 0, 0, 1, 0, 0));

    // Reset in RESP drops the transaction; a slave response meanwhile goes nowhere.
    slave_auto = 1'b0;
    m1_MCmd = 3'b010; m1_MAddr = 8'h44;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_seq_cmd", 32'(s_MCmd), 32'h2);
    s_SCmdAccept = 1'b1;
    @(negedge clk);
    check("rst_seq_acc", 32'(m1_SCmdAccept), 32'd1);
    @(posedge clk); #1;
    s_SCmdAccept = 1'b0; m1_MCmd = 3'b000; m1_MAddr = 8'h00;
    check("rst_seq_in_resp", 32'(arb_busy), 32'd1);
    reset = 1'b1;
    s_SResp = 2'b01; s_SData = 8'hAA;
    @(negedge clk);
    check_all_zero("rst_in_resp");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_rst");
    @(posedge clk); #1;
    s_SResp = 2'b00; s_SData = 8'h00;
    model_last = 1;
    slave_auto = 1'b1;
    @(posedge clk); #1;
    run_round(1'b0, mk(3'b000, 0, 0, 0, 1, 0, 0), 1'b1, mk(3'b010, 8'h45, 8'h00, 0, 1, 2'b01, 8'h67));

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 2);
      ta = rand_txn();
      tb = rand_txn();
      run_round(sel != 1, ta, sel != 0, tb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
